// File: rtl/seq_dffre_arb2_pkg.sv
// Shared types and constants for the two-requester arbitrated register.
// Holds the requester-id enum, the write-counter width and a small
// helper that names the requester on the other side of the arbiter.
package seq_dffre_arb2_pkg;

  // Requester identifiers; also used as the round-robin priority pointer.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  // Width of the optional accepted-write counter.
  localparam int COUNT_W = 8;

  // The requester that did not win, i.e. the one that gets priority next.
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/seq_dffre_arb2_reg.sv
// NBITS-wide storage register with synchronous active-high reset and a
// write enable. Reset wins over enable so a reset edge always restores
// RESET_VALUE regardless of what the arbiter is presenting.
module seq_dffre_arb2_reg #(
  parameter int               NBITS       = 8,
  parameter logic [NBITS-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NBITS-1:0] d,
  output logic [NBITS-1:0] q
);

  // Load reset value, else capture d when enabled, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_dffre_arb2.sv
// Two-requester round-robin arbiter in front of a shared register.
// Each cycle at most one requester is granted (rdy) and its data is
// written into q at the next rising edge; q, q_src and q_written follow
// with a latency of one cycle and no bypass. After every write the
// priority pointer moves to the requester that lost, and it holds
// across idle cycles.
// Optional feature: define SEQ_DFFRE_ARB2_COUNT_EN to add the wr_count
// output, an 8-bit wrapping count of accepted writes.
module seq_dffre_arb2
  import seq_dffre_arb2_pkg::*;
#(
  parameter int               NBITS       = 8,
  parameter logic [NBITS-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_val,
  output logic             req0_rdy,
  input  logic [NBITS-1:0] req0_data,
  input  logic             req1_val,
  output logic             req1_rdy,
  input  logic [NBITS-1:0] req1_data,
  output logic [NBITS-1:0] q,
  output logic             q_src,
  output logic             q_written
`ifdef SEQ_DFFRE_ARB2_COUNT_EN
  ,
  output logic [COUNT_W-1:0] wr_count
`endif
);

  req_id_t          prio;
  req_id_t          src_r;
  req_id_t          winner;
  logic             wr_en;
  logic [NBITS-1:0] wr_data;

  // Grants depend only on the val inputs, the pointer and reset, never on
  // data; the pointer breaks ties so the two grants are mutually exclusive.
  always_comb begin
    req0_rdy = !reset && req0_val && (!req1_val || (prio == REQ0));
    req1_rdy = !reset && req1_val && (!req0_val || (prio == REQ1));
  end

  // Steer the granted requester's data and id towards the storage.
  always_comb begin
    wr_en   = req0_rdy || req1_rdy;
    winner  = req1_rdy ? REQ1 : REQ0;
    wr_data = req1_rdy ? req1_data : req0_data;
  end

  seq_dffre_arb2_reg #(
    .NBITS       (NBITS),
    .RESET_VALUE (RESET_VALUE)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .en    (wr_en),
    .d     (wr_data),
    .q     (q)
  );

  // Track who wrote last, whether anything was written, and hand priority
  // to the loser after each write; all of it holds when nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio      <= REQ0;
      src_r     <= REQ0;
      q_written <= 1'b0;
    end else if (wr_en) begin
      prio      <= other_req(winner);
      src_r     <= winner;
      q_written <= 1'b1;
    end
  end

  assign q_src = src_r;

`ifdef SEQ_DFFRE_ARB2_COUNT_EN
  // Count accepted writes, wrapping naturally at the counter width.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
    end else if (wr_en) begin
      wr_count <= wr_count + COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_dffre_arb2.sv
// Directed, table-driven bench for seq_dffre_arb2 (NBITS=8, RESET_VALUE=0).
// Each vector drives inputs for one cycle, checks the grants before the
// edge and the registered outputs just after it. Hand-written sequences
// cover the no-bypass/data-independence corner and, when
// SEQ_DFFRE_ARB2_COUNT_EN is defined, the write counter wrap.
module tb_seq_dffre_arb2;
  import seq_dffre_arb2_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_val, req1_val;
  logic       req0_rdy, req1_rdy;
  logic [7:0] req0_data, req1_data;
  logic [7:0] q;
  logic       q_src;
  logic       q_written;
`ifdef SEQ_DFFRE_ARB2_COUNT_EN
  logic [COUNT_W-1:0] wr_count;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  seq_dffre_arb2 #(
    .NBITS       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req0_val),
    .req0_rdy  (req0_rdy),
    .req0_data (req0_data),
    .req1_val  (req1_val),
    .req1_rdy  (req1_rdy),
    .req1_data (req1_data),
    .q         (q),
    .q_src     (q_src),
    .q_written (q_written)
`ifdef SEQ_DFFRE_ARB2_COUNT_EN
    ,
    .wr_count  (wr_count)
`endif
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       e_rdy0;
    logic       e_rdy1;
    logic [7:0] e_q;
    logic       e_src;
    logic       e_wr;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  task automatic applyStimulus(input vec_t v);
    reset     = v.rst;
    req0_val  = v.v0;
    req1_val  = v.v1;
    req0_data = v.d0;
    req1_data = v.d1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst v0 v1 d0 d1 | rdy0 rdy1 q src written (q/src/written after the edge)
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'hab, 8'h00, 1'b1, 1'b0, 8'hab, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'hff, 8'hff, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5a, 1'b0, 1'b1, 8'h5a, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h3c, 1'b0, 1'b1, 8'h3c, 1'b1, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 8'hc3, 8'h22, 1'b1, 1'b0, 8'hc3, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1};

    reset     = 1'b1;
    req0_val  = 1'b0;
    req1_val  = 1'b0;
    req0_data = 8'h00;
    req1_data = 8'h00;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req0_rdy", i), 32'(req0_rdy), 32'(vecs[i].e_rdy0));
      checkOutput($sformatf("v%0d req1_rdy", i), 32'(req1_rdy), 32'(vecs[i].e_rdy1));
      checkOutput($sformatf("v%0d rdy_exclusive", i), 32'(req0_rdy & req1_rdy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d q", i), 32'(q), 32'(vecs[i].e_q));
      checkOutput($sformatf("v%0d q_src", i), 32'(q_src), 32'(vecs[i].e_src));
      checkOutput($sformatf("v%0d q_written", i), 32'(q_written), 32'(vecs[i].e_wr));
    end

    // No bypass: a granted write must not show on q before the edge.
    // State here: q=0x11, prio points at requester 1.
    reset     = 1'b0;
    req0_val  = 1'b1;
    req1_val  = 1'b0;
    req0_data = 8'h77;
    #1;
    checkOutput("nobypass req0_rdy", 32'(req0_rdy), 32'd1);
    checkOutput("nobypass q_before_edge", 32'(q), 32'h11);
    @(posedge clk);
    #1;
    checkOutput("nobypass q_after_edge", 32'(q), 32'h77);
    checkOutput("nobypass q_src", 32'(q_src), 32'd0);

    // Grant must not move when only data changes mid-cycle; the last data
    // presented before the edge is what gets stored.
    req1_val  = 1'b1;
    req1_data = 8'h99;
    #1;
    checkOutput("dataind req1_rdy", 32'(req1_rdy), 32'd1);
    checkOutput("dataind req0_rdy", 32'(req0_rdy), 32'd0);
    req1_data = 8'h00;
    req0_data = 8'h55;
    #1;
    checkOutput("dataind req1_rdy_after_data", 32'(req1_rdy), 32'd1);
    checkOutput("dataind req0_rdy_after_data", 32'(req0_rdy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("dataind q", 32'(q), 32'h00);
    checkOutput("dataind q_src", 32'(q_src), 32'd1);

`ifdef SEQ_DFFRE_ARB2_COUNT_EN
    // Counter: reset, 257 single-requester writes, wrap, then reset again.
    reset    = 1'b1;
    req0_val = 1'b0;
    req1_val = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cnt after_reset", 32'(wr_count), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 257; i++) begin
      req0_val  = 1'b1;
      req0_data = 8'(i);
      @(posedge clk);
      #1;
      if (i == 1)   checkOutput("cnt 1", 32'(wr_count), 32'd1);
      if (i == 255) checkOutput("cnt 255", 32'(wr_count), 32'd255);
      if (i == 256) checkOutput("cnt wrap_0", 32'(wr_count), 32'd0);
    end
    checkOutput("cnt 257", 32'(wr_count), 32'd1);
    checkOutput("cnt q_last", 32'(q), 32'h01);
    req0_val = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cnt idle_hold", 32'(wr_count), 32'd1);
    reset    = 1'b1;
    req0_val = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("cnt reset_clear", 32'(wr_count), 32'd0);
    reset    = 1'b0;
    req0_val = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
